// File: rtl/fft8_out_serializer.sv
// Buffers one 8-bin FFT frame and streams it out one complex bin per beat.
// Define FFT_OUT_PINGPONG_EN for two-bank ping-pong buffering.
module fft8_out_serializer #(
  parameter int DATA_W     = 32,
  parameter int SHIFT      = 0,
  parameter int DROP_CNT_W = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [DATA_W-1:0]     y0_real,
  input  logic [DATA_W-1:0]     y1_real,
  input  logic [DATA_W-1:0]     y2_real,
  input  logic [DATA_W-1:0]     y3_real,
  input  logic [DATA_W-1:0]     y4_real,
  input  logic [DATA_W-1:0]     y5_real,
  input  logic [DATA_W-1:0]     y6_real,
  input  logic [DATA_W-1:0]     y7_real,
  input  logic [DATA_W-1:0]     y0_imag,
  input  logic [DATA_W-1:0]     y1_imag,
  input  logic [DATA_W-1:0]     y2_imag,
  input  logic [DATA_W-1:0]     y3_imag,
  input  logic [DATA_W-1:0]     y4_imag,
  input  logic [DATA_W-1:0]     y5_imag,
  input  logic [DATA_W-1:0]     y6_imag,
  input  logic [DATA_W-1:0]     y7_imag,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_W-1:0]     out_real,
  output logic [DATA_W-1:0]     out_imag,
  output logic [2:0]            out_idx,
  output logic                  out_last,
  output logic                  busy,
  output logic                  frame_drop,
  output logic [DROP_CNT_W-1:0] drop_cnt
);

  // Half-LSB rounding constant; evaluates to zero when SHIFT is 0.
  localparam logic signed [DATA_W:0] RND = $signed(((DATA_W+1)'(1) << SHIFT) >> 1);

  logic [DATA_W-1:0]     yr [8];
  logic [DATA_W-1:0]     yi [8];
  logic [2:0]            idx_q, idx_d;
  logic                  frame_drop_q, frame_drop_d;
  logic [DROP_CNT_W-1:0] drop_cnt_q, drop_cnt_d;
  logic                  valid, busy_c, capture, fire, final_xfer;
  logic [DATA_W-1:0]     rd_re, rd_im;

  always_comb begin
    yr[0] = y0_real; yr[1] = y1_real; yr[2] = y2_real; yr[3] = y3_real;
    yr[4] = y4_real; yr[5] = y5_real; yr[6] = y6_real; yr[7] = y7_real;
    yi[0] = y0_imag; yi[1] = y1_imag; yi[2] = y2_imag; yi[3] = y3_imag;
    yi[4] = y4_imag; yi[5] = y5_imag; yi[6] = y6_imag; yi[7] = y7_imag;
  end

  function automatic logic [DATA_W-1:0] scale(input logic [DATA_W-1:0] y);
    logic signed [DATA_W:0] s;
    s = $signed({y[DATA_W-1], y}) + RND;
    s = s >>> SHIFT;
    return s[DATA_W-1:0];
  endfunction

  assign fire       = valid && out_ready;
  assign final_xfer = fire && (idx_q == 3'd7);
  assign capture    = in_valid && !busy_c;

`ifdef FFT_OUT_PINGPONG_EN
  logic [DATA_W-1:0] buf_re_q [2][8];
  logic [DATA_W-1:0] buf_im_q [2][8];
  logic [1:0]        full_q, full_d;
  logic              wr_q, rd_q;

  assign valid  = full_q[rd_q];
  assign busy_c = (&full_q) && !final_xfer;
  assign rd_re  = buf_re_q[rd_q][idx_q];
  assign rd_im  = buf_im_q[rd_q][idx_q];

  // Release before capture: when both banks are full, wr_q == rd_q and the
  // freed bank is refilled in the same cycle.
  always_comb begin
    full_d = full_q;
    if (final_xfer) full_d[rd_q] = 1'b0;
    if (capture)    full_d[wr_q] = 1'b1;
    idx_d = fire ? idx_q + 3'd1 : idx_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full_q <= '0;
      wr_q   <= 1'b0;
      rd_q   <= 1'b0;
      idx_q  <= '0;
      for (int unsigned b = 0; b < 2; b++)
        for (int unsigned k = 0; k < 8; k++) begin
          buf_re_q[b][k] <= '0;
          buf_im_q[b][k] <= '0;
        end
    end else begin
      full_q <= full_d;
      wr_q   <= wr_q ^ capture;
      rd_q   <= rd_q ^ final_xfer;
      idx_q  <= idx_d;
      if (capture)
        for (int unsigned k = 0; k < 8; k++) begin
          buf_re_q[wr_q][k] <= yr[k];
          buf_im_q[wr_q][k] <= yi[k];
        end
    end
  end
`else
  typedef enum logic {IDLE, DRAIN} state_t;
  state_t            state_q, state_d;
  logic [DATA_W-1:0] buf_re_q [8];
  logic [DATA_W-1:0] buf_im_q [8];

  assign valid  = (state_q == DRAIN);
  assign busy_c = valid && !(out_ready && (idx_q == 3'd7));
  assign rd_re  = buf_re_q[idx_q];
  assign rd_im  = buf_im_q[idx_q];

  always_comb begin
    state_d = state_q;
    idx_d   = fire ? idx_q + 3'd1 : idx_q;
    if (capture) begin
      state_d = DRAIN;
      idx_d   = '0;
    end else if (final_xfer) begin
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      for (int unsigned k = 0; k < 8; k++) begin
        buf_re_q[k] <= '0;
        buf_im_q[k] <= '0;
      end
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      if (capture)
        for (int unsigned k = 0; k < 8; k++) begin
          buf_re_q[k] <= yr[k];
          buf_im_q[k] <= yi[k];
        end
    end
  end
`endif

  always_comb begin
    frame_drop_d = in_valid && busy_c;
    drop_cnt_d   = drop_cnt_q;
    if (frame_drop_d && !(&drop_cnt_q)) drop_cnt_d = drop_cnt_q + DROP_CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_drop_q <= 1'b0;
      drop_cnt_q   <= '0;
    end else begin
      frame_drop_q <= frame_drop_d;
      drop_cnt_q   <= drop_cnt_d;
    end
  end

  assign out_valid  = valid;
  assign out_real   = valid ? scale(rd_re) : '0;
  assign out_imag   = valid ? scale(rd_im) : '0;
  assign out_idx    = valid ? idx_q : '0;
  assign out_last   = valid && (idx_q == 3'd7);
  assign busy       = busy_c;
  assign frame_drop = frame_drop_q;
  assign drop_cnt   = drop_cnt_q;

endmodule

// File: tb/tb_fft8_out_serializer.sv
// Directed, table-driven bench for fft8_out_serializer (both buffer builds).
module tb_fft8_out_serializer;

`ifdef FFT_OUT_PINGPONG_EN
  localparam bit PP = 1'b1;
`else
  localparam bit PP = 1'b0;
`endif

  logic        clk, rst, in_valid, out_ready;
  logic [31:0] yr [8];
  logic [31:0] yi [8];

  logic        ov, last, busy, fdrop;
  logic [31:0] ore, oim;
  logic [2:0]  oidx;
  logic [7:0]  cnt;

  logic        ov2, last2, busy2, fdrop2;
  logic [31:0] ore2, oim2;
  logic [2:0]  oidx2;
  logic [1:0]  cnt2;

  int nvec = 0;
  int nmis = 0;

  fft8_out_serializer #(.DATA_W(32), .SHIFT(0), .DROP_CNT_W(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid),
    .y0_real(yr[0]), .y1_real(yr[1]), .y2_real(yr[2]), .y3_real(yr[3]),
    .y4_real(yr[4]), .y5_real(yr[5]), .y6_real(yr[6]), .y7_real(yr[7]),
    .y0_imag(yi[0]), .y1_imag(yi[1]), .y2_imag(yi[2]), .y3_imag(yi[3]),
    .y4_imag(yi[4]), .y5_imag(yi[5]), .y6_imag(yi[6]), .y7_imag(yi[7]),
    .out_valid(ov), .out_ready(out_ready), .out_real(ore), .out_imag(oim),
    .out_idx(oidx), .out_last(last), .busy(busy), .frame_drop(fdrop), .drop_cnt(cnt)
  );

  fft8_out_serializer #(.DATA_W(32), .SHIFT(2), .DROP_CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid),
    .y0_real(yr[0]), .y1_real(yr[1]), .y2_real(yr[2]), .y3_real(yr[3]),
    .y4_real(yr[4]), .y5_real(yr[5]), .y6_real(yr[6]), .y7_real(yr[7]),
    .y0_imag(yi[0]), .y1_imag(yi[1]), .y2_imag(yi[2]), .y3_imag(yi[3]),
    .y4_imag(yi[4]), .y5_imag(yi[5]), .y6_imag(yi[6]), .y7_imag(yi[7]),
    .out_valid(ov2), .out_ready(out_ready), .out_real(ore2), .out_imag(oim2),
    .out_idx(oidx2), .out_last(last2), .busy(busy2), .frame_drop(fdrop2), .drop_cnt(cnt2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        iv;
    int          pat;
    logic        rdy;
    logic        ov;
    logic [2:0]  idx;
    logic [31:0] re;
    logic [31:0] im;
    logic        last;
    logic        busy;
    logic        drop;
    logic [7:0]  cnt;
  } vec_t;

  vec_t tbl[$];

  // Frame patterns: 0 -> (4k, -4k), 1 -> (100+k, 200+k), 2 -> (300+k, 400+k)
  function automatic logic [31:0] ere(input int pat, input int k);
    case (pat)
      0:       return 32'(4 * k);
      1:       return 32'(100 + k);
      default: return 32'(300 + k);
    endcase
  endfunction

  function automatic logic [31:0] eim(input int pat, input int k);
    case (pat)
      0:       return 32'(-4 * k);
      1:       return 32'(200 + k);
      default: return 32'(400 + k);
    endcase
  endfunction

  function automatic void add(input logic iv, input int pat, input logic rdy, input logic e_ov,
                              input int idx, input logic [31:0] re, input logic [31:0] im,
                              input logic e_last, input logic e_busy, input logic e_drop,
                              input int e_cnt);
    vec_t v;
    v.iv = iv; v.pat = pat; v.rdy = rdy; v.ov = e_ov; v.idx = 3'(idx);
    v.re = re; v.im = im; v.last = e_last; v.busy = e_busy; v.drop = e_drop;
    v.cnt = 8'(e_cnt);
    tbl.push_back(v);
  endfunction

  task automatic drive(input logic iv, input int pat, input logic rdy);
    in_valid  = iv;
    out_ready = rdy;
    for (int k = 0; k < 8; k++) begin
      yr[k] = ere(pat, k);
      yi[k] = eim(pat, k);
    end
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  initial begin
    int ib [10] = '{0, 1, 2, 2, 2, 3, 4, 5, 6, 7};
    logic rb [10] = '{1, 1, 0, 0, 1, 1, 1, 1, 1, 1};

    // Frame A, sink always ready
    add(1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 8; k++)
      add(0, 2, 1, 1, k, ere(0, k), eim(0, k), k == 7, !PP && (k != 7), 0, 0);
    add(0, 2, 1, 0, 0, 0, 0, 0, 0, 0, 0);

    // Frame B with out_ready 1,0,0,1 at bin 2
    add(1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int j = 0; j < 10; j++)
      add(0, 2, rb[j], 1, ib[j], ere(1, ib[j]), eim(1, ib[j]), ib[j] == 7,
          !PP && (!rb[j] || ib[j] != 7), 0, 0);
    add(0, 2, 1, 0, 0, 0, 0, 0, 0, 0, 0);

    if (!PP) begin
      // Arrival at beat 3 is dropped; arrival on the beat-7 transfer is kept
      add(1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
      for (int k = 0; k < 8; k++)
        add((k == 3) || (k == 7), ((k == 3) || (k == 7)) ? 1 : 2, 1, 1, k,
            ere(0, k), eim(0, k), k == 7, k != 7, k == 4, (k >= 4) ? 1 : 0);
      for (int k = 0; k < 8; k++)
        add(0, 2, 1, 1, k, ere(1, k), eim(1, k), k == 7, k != 7, 0, 1);
      add(0, 2, 1, 0, 0, 0, 0, 0, 0, 0, 1);
    end

    // Reset state
    rst = 1'b1;
    drive(0, 0, 0);
    #3;
    chk("reset out_valid", 32'(ov), 0);
    chk("reset out_idx", 32'(oidx), 0);
    chk("reset out_real", ore, 0);
    chk("reset busy", 32'(busy), 0);
    chk("reset frame_drop", 32'(fdrop), 0);
    chk("reset drop_cnt", 32'(cnt), 0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].iv, tbl[i].pat, tbl[i].rdy);
      #2;
      chk($sformatf("row%0d out_valid", i), 32'(ov), 32'(tbl[i].ov));
      chk($sformatf("row%0d out_idx", i), 32'(oidx), 32'(tbl[i].idx));
      chk($sformatf("row%0d out_real", i), ore, tbl[i].re);
      chk($sformatf("row%0d out_imag", i), oim, tbl[i].im);
      chk($sformatf("row%0d out_last", i), 32'(last), 32'(tbl[i].last));
      chk($sformatf("row%0d busy", i), 32'(busy), 32'(tbl[i].busy));
      chk($sformatf("row%0d frame_drop", i), 32'(fdrop), 32'(tbl[i].drop));
      chk($sformatf("row%0d drop_cnt", i), 32'(cnt), 32'(tbl[i].cnt));
      @(negedge clk);
    end

    // Asynchronous reset in the middle of a drain
    drive(1, 0, 1);
    @(negedge clk);
    drive(0, 2, 1);
    repeat (4) @(negedge clk);
    #1;
    chk("mid-drain idx", 32'(oidx), 4);
    chk("mid-drain real", ore, 32'd16);
    rst = 1'b1;
    #1;
    chk("async rst out_valid", 32'(ov), 0);
    chk("async rst out_idx", 32'(oidx), 0);
    chk("async rst out_real", ore, 0);
    chk("async rst drop_cnt", 32'(cnt), 0);
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #2;
      chk($sformatf("post-rst idle%0d out_valid", c), 32'(ov), 0);
      @(negedge clk);
    end

    // Rounding shift (second instance, SHIFT=2) including extreme inputs
    drive(1, 0, 1);
    for (int k = 0; k < 8; k++) begin
      yr[k] = '0;
      yi[k] = '0;
    end
    yr[0] = 32'd6;
    yi[0] = -32'sd6;
    yr[1] = -32'sd5;
    yi[1] = 32'h7FFF_FFFF;
    yr[2] = 32'h8000_0000;
    @(negedge clk);
    in_valid = 1'b0;
    #2;
    chk("shift2 bin0 real", ore2, 32'd2);
    chk("shift2 bin0 imag", oim2, 32'hFFFF_FFFF);
    chk("shift0 bin0 real", ore, 32'd6);
    chk("shift0 bin0 imag", oim, 32'hFFFF_FFFA);
    @(negedge clk);
    #2;
    chk("shift2 bin1 idx", 32'(oidx2), 1);
    chk("shift2 bin1 real", ore2, 32'hFFFF_FFFF);
    chk("shift2 bin1 imag max", oim2, 32'h2000_0000);
    @(negedge clk);
    #2;
    chk("shift2 bin2 real min", ore2, 32'hE000_0000);
    repeat (6) @(negedge clk);
    #2;
    chk("shift2 drained out_valid", 32'(ov2), 0);
    @(negedge clk);

    // Drop counter saturation (second instance has a 2-bit counter)
    for (int c = 0; c < 6; c++) begin
      drive(1, 0, 0);
      @(negedge clk);
    end
    drive(0, 0, 0);
    #2;
    chk("sat busy", 32'(busy), 1);
    chk("sat drop_cnt 8b", 32'(cnt), PP ? 32'd4 : 32'd5);
    chk("sat drop_cnt 2b", 32'(cnt2), 32'd3);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #2;
    chk("sat cleared", 32'(cnt2), 0);
    @(negedge clk);

`ifdef FFT_OUT_PINGPONG_EN
    // Three frames back to back with the sink stalled: third is dropped
    drive(1, 0, 0);
    #2;
    chk("pp f1 busy", 32'(busy), 0);
    @(negedge clk);
    drive(1, 1, 0);
    #2;
    chk("pp f2 busy", 32'(busy), 0);
    chk("pp f2 out_valid", 32'(ov), 1);
    @(negedge clk);
    drive(1, 2, 0);
    #2;
    chk("pp f3 busy", 32'(busy), 1);
    @(negedge clk);
    drive(0, 2, 1);
    #2;
    chk("pp frame_drop", 32'(fdrop), 1);
    chk("pp drop_cnt", 32'(cnt), 1);
    for (int j = 0; j < 16; j++) begin
      if (j > 0) begin
        @(negedge clk);
        #2;
      end
      chk($sformatf("pp beat%0d out_valid", j), 32'(ov), 1);
      chk($sformatf("pp beat%0d out_idx", j), 32'(oidx), 32'(j % 8));
      chk($sformatf("pp beat%0d out_real", j), ore, ere(j / 8, j % 8));
      chk($sformatf("pp beat%0d out_last", j), 32'(last), 32'((j % 8) == 7));
    end
    @(negedge clk);
    #2;
    chk("pp drained out_valid", 32'(ov), 0);
    chk("pp final drop_cnt", 32'(cnt), 1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule

// File: doc/fft8_out_serializer.md
Name: fft8_out_serializer

Overview:
- Sits directly downstream of the 8-point FFT core.
- Captures one parallel frame (y0..y7, real and imag) on the core's valid strobe.
- Streams the frame out one complex bin per beat, natural order 0..7, over a valid/ready handshake.
- Applies optional rounding right-shift scaling and counts frames lost to back-pressure.

Parameters:
- DATA_W, 32: width of each real/imag word, in and out.
- SHIFT, 0: arithmetic right shift applied on output with round-half-up; range 0..8.
- DROP_CNT_W, 8: width of the saturating dropped-frame counter.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  reset, asynchronous, active-high.
- in_valid  input  1  frame strobe from the FFT core valid output; each high cycle is one complete frame.
- y0_real..y7_real  input  DATA_W each  signed real parts of bins 0..7.
- y0_imag..y7_imag  input  DATA_W each  signed imaginary parts of bins 0..7.
- out_valid  output  1  current beat is valid.
- out_ready  input  1  sink accepts the beat.
- out_real  output  DATA_W  signed scaled real part of the current bin.
- out_imag  output  DATA_W  signed scaled imaginary part of the current bin.
- out_idx  output  3  bin index of the current beat, 0..7.
- out_last  output  1  high with out_valid when out_idx==7.
- busy  output  1  no buffer free; a frame arriving now would be dropped.
- frame_drop  output  1  one-cycle pulse when an arriving frame was discarded.
- drop_cnt  output  DROP_CNT_W  saturating count of dropped frames.

Behaviour:
- Reset values: state IDLE; out_valid, out_last, busy, frame_drop = 0; out_idx, drop_cnt = 0; buffers = 0.
  - Reset asserted mid-drain discards the buffered frame immediately.
- FSM, single-buffer build:
  - IDLE: in_valid=1 -> latch all 16 words into the buffer; go to DRAIN with out_idx=0. out_valid rises the cycle after capture (latency 1).
  - DRAIN: out_valid=1. A beat transfers on out_valid && out_ready; out_idx then increments.
  - On the transfer at out_idx==7 the buffer is released. Next state is IDLE, or DRAIN again (idx 0, no bubble) if in_valid=1 in that same cycle.
- Simultaneous events:
  - in_valid during DRAIN, not on the final transfer: frame dropped; frame_drop=1 next cycle; drop_cnt increments.
  - in_valid on the final transfer cycle: frame accepted (release-then-capture).
- busy = 1 whenever the arriving frame would be dropped this cycle. Combinational from state, out_idx and out_ready.
- Stall: while out_valid && !out_ready, out_real, out_imag, out_idx and out_last hold stable.
- Output data when out_valid=0: out_real, out_imag, out_idx and out_last are driven 0.
- Scaling:
  - SHIFT=0: pass-through.
  - SHIFT>0: out = (y + 2^(SHIFT-1)) >>> SHIFT, computed in DATA_W+1 signed bits, then truncated to DATA_W. This cannot overflow.
- drop_cnt saturates at all-ones and holds; it clears only on reset.
- Frames are never reordered. Buffered data is never overwritten before its last beat transfers.

Optional Feature:
- Macro FFT_OUT_PINGPONG_EN.
- Defined:
  - Two frame banks with a 1-bit write pointer, a 1-bit read pointer and per-bank full flags.
  - A capture goes into the free bank; the drain reads the oldest full bank.
  - A frame is dropped only when both banks are full and no final transfer occurs that cycle.
  - Back-to-back drains proceed with no idle cycle between frames.
- Not defined: single-buffer behaviour exactly as in Behaviour.

Test Plan:
- Reset, then one frame with bin k real=k*4, imag=-(k*4), SHIFT=0, out_ready=1 -> 8 consecutive beats starting 1 cycle after in_valid; idx 0..7; out_real 0,4,..,28; out_imag 0,-4,..,-28; out_last only on idx 7; drop_cnt=0.
- SHIFT=2, y0_real=6, y0_imag=-6, y1_real=-5 -> out_real(bin 0)=2, out_imag(bin 0)=-1, out_real(bin 1)=-1.
- out_ready toggling 1,0,0,1 during a drain -> outputs held through the stall cycles; all 8 bins delivered exactly once, in order.
- Single-buffer build, second in_valid at beat 3 -> frame_drop pulse, drop_cnt=1. Second in_valid on the beat-7 transfer -> accepted; next cycle idx=0 of the new frame.
- FFT_OUT_PINGPONG_EN defined, three frames on consecutive cycles with out_ready=0 -> frames 1 and 2 kept, frame 3 dropped (drop_cnt=1). Releasing out_ready yields 16 beats, frame 1 then frame 2, with no gap.
- rst asserted at beat 4 of a drain -> out_valid=0 immediately (asynchronous); after release, idle until the next in_valid; drop_cnt=0.
